// File: rtl/phy_rx_lane.sv
// phy_rx_lane: receive side of one serial PHY lane.
// Finds byte alignment from COM symbols in the bit stream. Once locked, it
// drops COM/IDL symbols and packs the data bytes into 32-bit words, first
// byte in [31:24]. The active output means the lane is locked.
module phy_rx_lane #(
    parameter logic [7:0]  COM_SYMBOL  = 8'hBC,
    parameter logic [7:0]  IDL_SYMBOL  = 8'h7C,
    parameter int unsigned ALIGN_COUNT = 4,
    parameter int unsigned LOSS_COUNT  = 4
) (
    input  logic        clk_32f,
    input  logic        reset_L,
    input  logic        data_in,
    output logic        active,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [31:0] data_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_LOCKING,
        ST_ACTIVE
    } state_t;

    localparam logic [3:0] ALIGN_N = 4'(ALIGN_COUNT);
    localparam logic [3:0] LOSS_N  = 4'(LOSS_COUNT);

    state_t      r_state;
    // Only the seven most recent bits are kept. Together with the incoming
    // bit they form the byte that completes on this edge.
    logic [6:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_com_cnt;
    logic [3:0]  r_loss_cnt;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;
    logic        r_active;
    logic [7:0]  r_byte_out;
    logic        r_byte_valid;
    logic [31:0] r_data_out;
    logic        r_valid_out;

    logic [7:0]  w_cand;
    logic        w_is_com;
    logic        w_is_idl;
    logic        w_boundary;
    logic [31:0] w_word_next;

    assign w_cand     = {r_sr, data_in};
    assign w_is_com   = (w_cand == COM_SYMBOL);
    assign w_is_idl   = (w_cand == IDL_SYMBOL);
    assign w_boundary = (r_bit_cnt == 3'd7);

    // Word buffer with the candidate byte dropped into the lane picked by
    // byte_idx. Lane 0 is the most significant byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_word_next[31-8*gi -: 8] =
                (r_byte_idx == 2'(gi)) ? w_cand : r_word[31-8*gi -: 8];
        end
    endgenerate

    // Alignment FSM, byte/word assembly and registered outputs.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            r_state      <= ST_SEARCH;
            r_sr         <= 7'd0;
            r_bit_cnt    <= 3'd0;
            r_com_cnt    <= 4'd0;
            r_loss_cnt   <= 4'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 32'd0;
            r_active     <= 1'b0;
            r_byte_out   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_data_out   <= 32'd0;
            r_valid_out  <= 1'b0;
        end else begin
            r_sr         <= w_cand[6:0];
            r_byte_valid <= 1'b0;
            r_valid_out  <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    // Bit-granular hunt: any edge that completes a COM
                    // becomes the byte boundary.
                    r_bit_cnt <= 3'd0;
                    if (w_is_com) begin
                        r_loss_cnt <= 4'd0;
                        r_byte_idx <= 2'd0;
                        if (ALIGN_N == 4'd1) begin
                            r_state   <= ST_ACTIVE;
                            r_active  <= 1'b1;
                            r_com_cnt <= 4'd0;
                        end else begin
                            r_state   <= ST_LOCKING;
                            r_com_cnt <= 4'd1;
                        end
                    end
                end
                ST_LOCKING: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_com) begin
                            if (r_com_cnt + 4'd1 == ALIGN_N) begin
                                r_state    <= ST_ACTIVE;
                                r_active   <= 1'b1;
                                r_com_cnt  <= 4'd0;
                                r_loss_cnt <= 4'd0;
                                r_byte_idx <= 2'd0;
                            end else begin
                                r_com_cnt <= r_com_cnt + 4'd1;
                            end
                        end else begin
                            r_state   <= ST_SEARCH;
                            r_com_cnt <= 4'd0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_boundary) begin
                        if (w_is_com) begin
                            // A COM discards the partial word. A run of
                            // them means the link restarted alignment.
                            r_byte_idx <= 2'd0;
                            if (r_loss_cnt + 4'd1 == LOSS_N) begin
                                r_state    <= ST_SEARCH;
                                r_active   <= 1'b0;
                                r_loss_cnt <= 4'd0;
                            end else begin
                                r_loss_cnt <= r_loss_cnt + 4'd1;
                            end
                        end else if (w_is_idl) begin
                            // Idle filler: the partial word is kept.
                            r_loss_cnt <= 4'd0;
                        end else begin
                            r_loss_cnt   <= 4'd0;
                            r_byte_out   <= w_cand;
                            r_byte_valid <= 1'b1;
                            r_word       <= w_word_next;
                            r_byte_idx   <= r_byte_idx + 2'd1;
                            if (r_byte_idx == 2'd3) begin
                                r_data_out  <= w_word_next;
                                r_valid_out <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign active     = r_active;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign data_out   = r_data_out;
    assign valid_out  = r_valid_out;

endmodule

// File: doc/phy_rx_lane.md
Name: phy_rx_lane

Overview:
Receive-side lane of the PHY, the counterpart to the transmit serializer. It takes one serial lane bit-stream at the bit clock and finds byte alignment from COM symbols. Once aligned it strips COM and IDLE symbols and packs the remaining data bytes into 32-bit words with a valid strobe, which feed the RX-side lane merger. Its "active" output signals a locked lane.

Parameters:
COM_SYMBOL, 8'hBC, comma/alignment symbol
IDL_SYMBOL, 8'h7C, idle filler symbol (never data)
ALIGN_COUNT, 4, consecutive aligned COMs required to declare lock (range 1..15)
LOSS_COUNT, 4, consecutive aligned COMs in ACTIVE that drop lock and restart alignment (range 2..15)

Ports:
clk_32f  input  1  bit clock; all logic on rising edge
reset_L  input  1  asynchronous, active-low reset
data_in  input  1  serial lane data, MSB-first per byte, sampled every clk_32f edge
active  output  1  lane locked (state ACTIVE)
byte_out  output  8  last received data byte (COM/IDL never appear here)
byte_valid  output  1  one-cycle strobe, byte_out updated
data_out  output  32  assembled word, first received byte in [31:24]
valid_out  output  1  one-cycle strobe, data_out updated

Behaviour:
- Reset (reset_L=0, async): state=SEARCH; shift register, bit_cnt, com_cnt, byte_idx, word buffer cleared; active=0, byte_out=0, byte_valid=0, data_out=0, valid_out=0. Deassertion takes effect at the next rising edge. Reset mid-operation discards any partial word and loses lock immediately.
- Shift register: sr <= {sr[6:0], data_in} every edge. "cand" = {sr[6:0], data_in}, the byte completed at this edge.
- SEARCH:
  - Cand is compared every edge (bit-granular).
  - cand==COM_SYMBOL -> LOCKING, com_cnt=1, bit_cnt=0. That edge is the byte boundary.
  - If ALIGN_COUNT==1, go directly to ACTIVE instead.
- Byte boundary: in LOCKING/ACTIVE, bit_cnt counts 0..7 and wraps. A byte completes at the edge where bit_cnt==7.
- LOCKING, at each byte boundary:
  - cand==COM: com_cnt++. When com_cnt reaches ALIGN_COUNT -> ACTIVE; active=1 from that edge.
  - Any other byte: back to SEARCH, com_cnt=0.
- ACTIVE, at each byte boundary:
  - Data byte (cand not COM and not IDL):
    - byte_out<=cand and byte_valid=1 at that same edge (output latency 1 edge after the last bit is sampled).
    - Byte is written into the word buffer at byte_idx (0 -> [31:24] ... 3 -> [7:0]) and byte_idx++.
    - When byte_idx==3: data_out<=complete word, valid_out=1 on the same edge as that byte's byte_valid; byte_idx wraps to 0.
  - IDL: no strobe. Partial word retained; IDL does not break a word.
  - COM: no strobe; partial word discarded (byte_idx=0); loss counter++.
    - Loss counter reaches LOSS_COUNT -> SEARCH, active=0 at that edge.
    - Any non-COM byte clears the loss counter.
- byte_valid and valid_out are high for exactly one cycle. data_out and byte_out hold their value between strobes.
- Maximum valid_out rate is once per 32 clocks.
- No data output is ever produced outside ACTIVE.

Test Plan:
1. Reset held 5 clocks while data_in toggles, then released with data_in=0 for 40 clocks -> active=0, byte_valid=0, valid_out=0, data_out=0 throughout.
2. 3 garbage bits, then 4x 8'hBC, then bytes 8'h12,8'h34,8'h56,8'h78 ->
   - active rises at the 4th COM boundary (bit 35).
   - byte_valid pulses 4 times with byte_out=12,34,56,78.
   - valid_out pulses once with data_out=32'h12345678, coincident with the byte 78 strobe.
3. After lock: 8'hAA, 7C, 7C, BB, CC, DD -> the 7C bytes are skipped; data_out=32'hAABBCCDD, valid_out=1 once.
4. After lock: 8'h11, 8'h22, then one 8'hBC, then 8'h33,44,55,66 ->
   - Partial 1122 is discarded; active stays 1.
   - Next valid_out gives data_out=32'h33445566.
5. Lock, then 4 consecutive BC -> active falls at the 4th boundary. A later 4x BC relocks.
   - Also: 3x BC then 8'h00 during LOCKING -> returns to SEARCH, active never rises.
6. reset_L pulsed low for 1 clock mid-word after 8'h11,22,33 -> all outputs 0 asynchronously; relock needed; no stale bytes appear in the next data_out.
